spi_slave_rx: RTL

SPI receive endpoint for the 12-bit serial link driven by spi_master (sclk/mosi/cs, cs active-low, LSB first). It runs entirely in the system clk domain. It oversamples sclk, cs and mosi through synchronizers and reassembles each frame into a parallel word. It presents the word on dout with a one-cycle done strobe and flags malformed frames.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_sync_edge.sv | 45 ++++
 rtl/spi_slave_rx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Definitions shared by the SPI link blocks. These are the frame
//               width shared with spi_master, the default synchronizer depth
//               and the receive FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Frame width used by both ends of the link.
  localparam int SPI_DATA_W      = 12;
  // Default flip-flop depth for asynchronous pin synchronizers.
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } spi_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : Multi-flop synchronizer followed by one history flop. It gives
//               the synchronized level and single-cycle rise/fall strobes of
//               an asynchronous input.
// Ports       : clk   - system clock
//               rst   - synchronous active-high reset
//               din   - asynchronous input pin
//               level - synchronized level (last synchronizer stage)
//               rise  - one-clk strobe on a synchronized 0->1 transition
//               fall  - one-clk strobe on a synchronized 1->0 transition
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
  parameter int STAGES    = 2,     // minimum 2
  parameter bit RESET_VAL = 1'b0   // idle level of the pin
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {STAGES{RESET_VAL}};
      hist <= RESET_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      hist <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule
`default_nettype wire

// File: rtl/spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_rx
// Description : SPI receive endpoint (cs active-low, mode with data sampled on
//               rising sclk). It works entirely in the clk domain by
//               oversampling sclk/cs/mosi. It reassembles DATA_W-bit frames
//               and presents each frame on dout with a one-clk done strobe.
//               Short (aborted) or over-clocked frames raise a one-clk
//               frame_err strobe.
// Ports       : clk       - system clock
//               rst       - synchronous active-high reset
//               sclk      - serial clock from master (asynchronous)
//               mosi      - serial data from master (asynchronous)
//               cs        - chip select, active-low (asynchronous)
//               dout      - last complete frame, held until the next one
//               done      - one-clk pulse when dout updates
//               frame_err - one-clk pulse on an aborted/over-clocked frame
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES,
  parameter bit LSB_FIRST   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  // The synchronizer chains need SYNC_STAGES+1 clocks after reset before
  // their level and history flops both reflect the real pins.
  localparam int SETTLE   = SYNC_STAGES + 1;
  localparam int SETTLE_W = $clog2(SETTLE + 1);

  // --------------------------------------------------------------------------
  // Input synchronization and edge detection
  // --------------------------------------------------------------------------
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (sclk),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (cs),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // mosi has the same depth as sclk, so the sampled bit lines up with the
  // rise strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sync <= '0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Only the strobes drive the FSM; the levels and sclk fall are not needed.
  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_lvl, sclk_fall, cs_lvl};

  // --------------------------------------------------------------------------
  // Post-reset settle window. This keeps a cs already low at reset release
  // from looking like a fresh falling edge while the chain flushes.
  // --------------------------------------------------------------------------
  logic [SETTLE_W-1:0] settle_cnt;
  logic                settled;

  assign settled = (settle_cnt == SETTLE_W'(SETTLE));

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (!settled) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FSM and datapath
  // --------------------------------------------------------------------------
  spi_rx_state_t     state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt, shifted;
  logic              ovf, ovf_nxt;
  logic [DATA_W-1:0] dout_nxt;
  logic              done_nxt, err_nxt;

  // After DATA_W shifts, the first bit lands in dout[0] (LSB first) or in
  // dout[DATA_W-1] (MSB first).
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign shifted = {mosi_s, shreg[DATA_W-1:1]};
    end else begin : g_msb_first
      assign shifted = {shreg[DATA_W-2:0], mosi_s};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ovf       <= 1'b0;
      dout      <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      ovf       <= ovf_nxt;
      dout      <= dout_nxt;
      done      <= done_nxt;
      frame_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    ovf_nxt     = ovf;
    dout_nxt    = dout;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (cs_fall && settled) begin
          state_nxt   = RECV;
          bit_cnt_nxt = '0;
          shreg_nxt   = '0;
          ovf_nxt     = 1'b0;
        end
      end

      RECV: begin
        // A cs_rise takes priority over a coincident sclk_rise. That bit is
        // dropped, so the frame is judged on the count without it.
        if (cs_rise) begin
          state_nxt = IDLE;
          err_nxt   = (bit_cnt < CNT_FULL);
        end else if (sclk_rise) begin
          shreg_nxt = shifted;
          if (bit_cnt != CNT_FULL) begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
          if (bit_cnt == CNT_LAST) begin
            dout_nxt  = shifted;
            done_nxt  = 1'b1;
            state_nxt = HOLD;
          end
        end
      end

      HOLD: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          err_nxt   = ovf;
        end else if (sclk_rise) begin
          ovf_nxt = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire
